// File: rtl/slow_clock_gen.sv
// slow_clock_gen: multi-channel programmable slow-clock generator.
// Each channel produces a 50 % duty square wave and a one-cycle tick on every
// toggle, with a runtime-loadable half-period. Everything is synchronous to
// CLOCK; the outputs are data signals and must not be routed as clocks.
//
// Build option: define SLOW_CLOCK_GEN_SYNC_EN to honour the SYNC input
// (restart all channels in phase). Without it SYNC is accepted but ignored.
module slow_clock_gen #(
  parameter int                CHANNELS     = 4,
  parameter int                WIDTH        = 20,
  parameter logic [WIDTH-1:0]  DEFAULT_HALF = {WIDTH{1'b1}}
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [CHANNELS-1:0]  ENABLE,
  input  logic [CHANNELS-1:0]  DIV_LOAD,
  input  logic [WIDTH-1:0]     DIV_VALUE,
  input  logic                 SYNC,
  output logic [CHANNELS-1:0]  OUT,
  output logic [CHANNELS-1:0]  TICK
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // Global in-phase restart request shared by every channel.
  logic sync_hit;

`ifdef SLOW_CLOCK_GEN_SYNC_EN
  assign sync_hit = SYNC;
`else
  // SYNC is kept on the port list for a uniform footprint but drives nothing.
  logic unused_sync;
  assign unused_sync = SYNC;
  assign sync_hit    = 1'b0;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [WIDTH-1:0] half_reg;
    logic [WIDTH-1:0] count_reg;
    logic             out_reg;
    logic             tick_reg;
    logic             terminal;

    // Equality against the programmed half-period; the counter is always
    // reset to zero whenever HALF changes, so it can never overshoot.
    assign terminal = (count_reg == half_reg);

    // Per-channel divider: reset > sync > load > count > hold.
    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        half_reg  <= DEFAULT_HALF;
        count_reg <= ZERO;
        out_reg   <= 1'b0;
        tick_reg  <= 1'b0;
      end else if (sync_hit) begin
        count_reg <= ZERO;
        out_reg   <= 1'b0;
        tick_reg  <= 1'b0;
      end else if (DIV_LOAD[gi]) begin
        // A terminal count coinciding with the load is discarded on purpose.
        half_reg  <= DIV_VALUE;
        count_reg <= ZERO;
        tick_reg  <= 1'b0;
      end else if (ENABLE[gi]) begin
        if (terminal) begin
          count_reg <= ZERO;
          out_reg   <= ~out_reg;
          tick_reg  <= 1'b1;
        end else begin
          count_reg <= count_reg + ONE;
          tick_reg  <= 1'b0;
        end
      end else begin
        tick_reg  <= 1'b0;
      end
    end

    assign OUT[gi]  = out_reg;
    assign TICK[gi] = tick_reg;
  end

endmodule

// File: tb/tb_slow_clock_gen.sv
// Directed bench for slow_clock_gen with CHANNELS=4, WIDTH=4, DEFAULT_HALF=15.
// Expected values are hand-computed edge counts relative to reset or load.
module tb_slow_clock_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic [3:0] div_load;
  logic [3:0] div_value;
  logic       sync;
  logic [3:0] out;
  logic [3:0] tick;

  int checks = 0;
  int errors = 0;

  slow_clock_gen #(
    .CHANNELS    (4),
    .WIDTH       (4),
    .DEFAULT_HALF(4'd15)
  ) dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .ENABLE   (enable),
    .DIV_LOAD (div_load),
    .DIV_VALUE(div_value),
    .SYNC     (sync),
    .OUT      (out),
    .TICK     (tick)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reset with the divider mid-period; outputs must be zero, no partial tick.
  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    check("rst_out", 32'(out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic exp_out;
    logic exp_tick;

    rst = 1'b1; enable = 4'hF; div_load = 4'h0; div_value = 4'h0; sync = 1'b0;
    steps(3);
    do_reset();

    // Default half 15: first toggle at 16th edge, period 32.
    steps(15);
    check("def_pre_out", 32'(out), 32'h0);
    check("def_pre_tick", 32'(tick), 32'h0);
    step();
    check("def_t16_out", 32'(out), 32'hF);
    check("def_t16_tick", 32'(tick), 32'hF);
    step();
    check("def_t17_tick", 32'(tick), 32'h0);
    steps(14);
    check("def_t31_out", 32'(out), 32'hF);
    step();
    check("def_t32_out", 32'(out), 32'h0);
    check("def_t32_tick", 32'(tick), 32'hF);

    // Load half 2 on channel 0: toggle every 3 edges, others untouched.
    div_load = 4'b0001; div_value = 4'd2;
    step();
    div_load = 4'b0000;
    check("ld0_out", 32'(out[0]), 32'h0);
    check("ld0_tick", 32'(tick[0]), 32'h0);
    exp_out = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_tick = (i % 3 == 0);
      if (exp_tick) exp_out = ~exp_out;
      check($sformatf("ch0_out_%0d", i), 32'(out[0]), 32'(exp_out));
      check($sformatf("ch0_tick_%0d", i), 32'(tick[0]), 32'(exp_tick));
    end
    check("ch123_out", 32'(out[3:1]), 32'h0);
    check("ch123_tick", 32'(tick[3:1]), 32'h0);

    // Half 0 on channel 1: toggles each edge, tick stuck high.
    do_reset();
    div_load = 4'b0010; div_value = 4'd0;
    step();
    div_load = 4'b0000;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("f2_out_%0d", i), 32'(out[1]), 32'(i % 2));
      check($sformatf("f2_tick_%0d", i), 32'(tick[1]), 32'h1);
    end

    // Half 3 on channel 0, disable for 5 cycles after 2 counts.
    do_reset();
    div_load = 4'b0001; div_value = 4'd3;
    step();
    div_load = 4'b0000;
    steps(2);
    enable = 4'b1110;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("hold_tick_%0d", i), 32'(tick[0]), 32'h0);
      check($sformatf("hold_out_%0d", i), 32'(out[0]), 32'h0);
    end
    enable = 4'hF;
    step();
    check("stall_pre_out", 32'(out[0]), 32'h0);
    check("stall_pre_tick", 32'(tick[0]), 32'h0);
    step();
    check("stall_tgl_out", 32'(out[0]), 32'h1);
    check("stall_tgl_tick", 32'(tick[0]), 32'h1);

    // Load channel 2 exactly at its terminal count: toggle discarded.
    do_reset();
    div_load = 4'b0100; div_value = 4'd3;
    step();
    div_load = 4'b0000;
    steps(3);
    div_load = 4'b0100; div_value = 4'd5;
    step();
    div_load = 4'b0000;
    check("ldtc_out", 32'(out[2]), 32'h0);
    check("ldtc_tick", 32'(tick[2]), 32'h0);
    steps(5);
    check("ldtc_pre_out", 32'(out[2]), 32'h0);
    step();
    check("ldtc_tgl_out", 32'(out[2]), 32'h1);
    check("ldtc_tgl_tick", 32'(tick[2]), 32'h1);

    // Channels 0 and 1 with equal half 2 but one edge apart, then SYNC.
    do_reset();
    div_load = 4'b0001; div_value = 4'd2;
    step();
    div_load = 4'b0010;
    step();
    div_load = 4'b0000;
    steps(2);
    check("ph_out", 32'(out[1:0]), 32'h1);
    sync = 1'b1;
    step();
    sync = 1'b0;
`ifdef SLOW_CLOCK_GEN_SYNC_EN
    check("sync_out", 32'(out), 32'h0);
    check("sync_tick", 32'(tick), 32'h0);
    steps(3);
    check("sync_al_out", 32'(out[1:0]), 32'h3);
    check("sync_al_tick", 32'(tick[1:0]), 32'h3);
`else
    check("nosync_out", 32'(out[1:0]), 32'h3);
    check("nosync_tick", 32'(tick[1:0]), 32'h2);
    steps(3);
    check("nosync_out3", 32'(out[1:0]), 32'h0);
    check("nosync_tick3", 32'(tick[1:0]), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_clock_gen.md
# slow_clock_gen

Multi-channel programmable slow-clock generator. It derives CHANNELS independent square-wave outputs and matching single-cycle tick strobes from the board clock, each with a runtime-loadable half-period. It sits beside the top-level clock input and feeds display multiplexing, debouncing and LED blink logic that need rates far below CLOCK. All outputs are synchronous to CLOCK; none is used as a clock net.

## Interface
- CHANNELS, 4, number of independent divider channels (1..8)
- WIDTH, 20, half-period counter width in bits (2..32)
- DEFAULT_HALF, 2^WIDTH-1, half-period value loaded into every channel at reset
---
- CLOCK  input  1  system clock; all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  CHANNELS  per-channel run enable; low freezes that channel
- DIV_LOAD  input  CHANNELS  per-channel strobe; loads DIV_VALUE as new half-period
- DIV_VALUE  input  WIDTH  half-period value shared by all load strobes
- SYNC  input  1  restart all channels in phase (active only with SLOW_CLOCK_GEN_SYNC_EN)
- OUT  output  CHANNELS  square-wave outputs, 50 % duty
- TICK  output  CHANNELS  one-cycle strobe coincident with every OUT toggle

## Operation
- Per channel c: registers HALF[c] (WIDTH), COUNT[c] (WIDTH), OUT[c], TICK[c].
- Output frequency: f_CLOCK / (2*(HALF[c]+1)); HALF=0 gives f_CLOCK/2.
- Per-edge priority, highest first: RESET > SYNC > DIV_LOAD[c] > ENABLE[c] count > hold.
- RESET: HALF <= DEFAULT_HALF, COUNT <= 0, OUT <= 0, TICK <= 0, all channels.
- SYNC (macro defined): COUNT <= 0, OUT <= 0, TICK <= 0 on all channels; HALF kept; a coincident DIV_LOAD is ignored.
- DIV_LOAD[c]: HALF[c] <= DIV_VALUE, COUNT[c] <= 0, OUT[c] unchanged, TICK[c] <= 0; takes effect regardless of ENABLE[c]. A pending terminal count in the same cycle is discarded (no toggle).
- Count (ENABLE[c]=1, no load): if COUNT[c]==HALF[c] then COUNT[c] <= 0, OUT[c] <= ~OUT[c], TICK[c] <= 1; else COUNT[c] <= COUNT[c]+1, TICK[c] <= 0.
- Hold (ENABLE[c]=0): COUNT, OUT frozen; TICK[c] <= 0.
- Counter never exceeds HALF[c]; comparison is equality, wrap at HALF, no modular overflow of WIDTH bits required.
- Channels are fully independent except for shared DIV_VALUE and SYNC.

## Timing
- All outputs registered; no combinational input-to-output path.
- Reset values: OUT = 0, TICK = 0 on every channel.
- After RESET or DIV_LOAD at edge n (COUNT=0), with ENABLE held high: first toggle at edge n+HALF+1, then every HALF+1 edges.
- TICK[c] high for exactly one cycle, same cycle OUT[c] changes; HALF=0 gives TICK constantly high while enabled.
- ENABLE low for k cycles stretches the current half-period by exactly k cycles.
- RESET asserted mid-period: effective at that edge; no partial tick emitted.

## Configuration
- SLOW_CLOCK_GEN_SYNC_EN defined: SYNC input honoured as above.
- Undefined: SYNC port present but ignored; no SYNC logic synthesised; channels only realigned by RESET or individual DIV_LOAD.

## Test plan
- Reset, CHANNELS=4, WIDTH=4, DEFAULT_HALF=15, ENABLE=4'hF -> OUT=0 during reset; first OUT toggle and TICK at 16th edge after release, period 32 cycles.
- DIV_LOAD=4'b0001, DIV_VALUE=2 -> channel 0 toggles every 3 cycles (period 6), TICK[0] one cycle wide; channels 1..3 unaffected.
- DIV_VALUE=0 loaded on channel 1 -> OUT[1] toggles every edge (f/2), TICK[1] constantly 1.
- Channel 0 with HALF=3, ENABLE[0] low 5 cycles mid-period -> toggle delayed by exactly 5 cycles, TICK[0]=0 while disabled.
- DIV_LOAD[2] on the cycle COUNT[2]==HALF[2] -> no toggle, no tick; next toggle HALF_new+1 edges later.
- With macro: channels at differing phases, pulse SYNC -> all OUT=0, COUNT=0 next cycle, equal-HALF channels toggle simultaneously thereafter; without macro: SYNC has no effect.
